pipe_stage_elastic: RTL

- Parametrised successor to the fixed MIPS inter-stage registers (F/D, D/E, E/M, M/W).
- One module carries an arbitrary control/data payload between two pipeline stages, plus pc, delay-slot flag and exception code.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, bubble insertion that preserves pc/slot, and exception-request flush to the handler address.
- One instance sits between each pair of stages in the P7 core.

---
 rtl/pipe_stage_elastic.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake, optional 2-entry skid buffer,
// hazard bubble insertion preserving pc/slot, and exception flush to the handler address.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned EXC_W      = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int unsigned SKID       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic              in_slot,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic              out_slot,
    output logic [EXC_W-1:0]  out_exc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              h_valid, n_h_valid;
    logic [31:0]       h_pc, n_h_pc;
    logic              h_slot, n_h_slot;
    logic [EXC_W-1:0]  h_exc, n_h_exc;
    logic [DATA_W-1:0] h_data, n_h_data;

    logic              s_valid, n_s_valid;
    logic [31:0]       s_pc, n_s_pc;
    logic              s_slot, n_s_slot;
    logic [EXC_W-1:0]  s_exc, n_s_exc;
    logic [DATA_W-1:0] s_data, n_s_data;

    logic rdy_q;
    logic accept, drain;

    // rdy_q resets to 1, so in_ready reads 1 for as long as rst is held in either mode
    assign in_ready  = (SKID != 0) ? rdy_q : (~h_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign drain     = h_valid & out_ready;

    assign out_valid = h_valid;
    assign out_pc    = h_pc;
    assign out_slot  = h_slot;
    assign out_exc   = h_exc;
    assign out_data  = h_data;
    assign occupancy = {1'b0, h_valid} + {1'b0, s_valid};

    always_comb begin
        n_h_valid = h_valid;
        n_h_pc    = h_pc;
        n_h_slot  = h_slot;
        n_h_exc   = h_exc;
        n_h_data  = h_data;
        n_s_valid = s_valid;
        n_s_pc    = s_pc;
        n_s_slot  = s_slot;
        n_s_exc   = s_exc;
        n_s_data  = s_data;

        if (req) begin
            n_h_valid = 1'b0;
            n_s_valid = 1'b0;
            n_h_pc    = HANDLER_PC;
            n_h_slot  = 1'b0;
            n_h_exc   = '0;
            n_h_data  = '0;
        end else if (flush) begin
            n_h_valid = 1'b0;
            n_s_valid = 1'b0;
            n_h_exc   = '0;
            n_h_data  = '0;
            // Bubble inherits the youngest known pc/slot; an idle H already holds the last one
            if (accept) begin
                n_h_pc   = in_pc;
                n_h_slot = in_slot;
            end else if (s_valid) begin
                n_h_pc   = s_pc;
                n_h_slot = s_slot;
            end
        end else if (!h_valid || drain) begin
            if (s_valid) begin
                n_h_valid = 1'b1;
                n_h_pc    = s_pc;
                n_h_slot  = s_slot;
                n_h_exc   = s_exc;
                n_h_data  = s_data;
                n_s_valid = 1'b0;
            end else if (accept) begin
                n_h_valid = 1'b1;
                n_h_pc    = in_pc;
                n_h_slot  = in_slot;
                n_h_exc   = in_exc;
                n_h_data  = in_data;
            end else begin
                n_h_valid = 1'b0;
            end
        end else if (accept && SKID != 0) begin
            n_s_valid = 1'b1;
            n_s_pc    = in_pc;
            n_s_slot  = in_slot;
            n_s_exc   = in_exc;
            n_s_data  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_valid <= 1'b0;
            h_pc    <= RESET_PC;
            h_slot  <= 1'b0;
            h_exc   <= '0;
            h_data  <= '0;
            s_valid <= 1'b0;
            s_pc    <= '0;
            s_slot  <= 1'b0;
            s_exc   <= '0;
            s_data  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            h_valid <= n_h_valid;
            h_pc    <= n_h_pc;
            h_slot  <= n_h_slot;
            h_exc   <= n_h_exc;
            h_data  <= n_h_data;
            s_valid <= n_s_valid;
            s_pc    <= n_s_pc;
            s_slot  <= n_s_slot;
            s_exc   <= n_s_exc;
            s_data  <= n_s_data;
            rdy_q   <= ~n_s_valid;
        end
    end

endmodule
